// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampled UART receiver presenting characters on a valid/ready output.
// Define UART_RX_PARITY_EN to add the parity bit check and the parity_odd_i input.
module uart_rx_ctrl #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    input  logic                 baud_tick_i,
    input  logic                 ready_i,
`ifdef UART_RX_PARITY_EN
    input  logic                 parity_odd_i,
`endif
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`ifdef UART_RX_PARITY_EN
    localparam state_e AFTER_DATA = PARITY;
`else
    localparam state_e AFTER_DATA = STOP;
`endif

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [TW-1:0]          tick_q;
    logic [BW-1:0]          bit_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   data_q;
    logic                   rxs;
    logic                   rxs_prev_q;
    logic                   armed_q;
    logic                   mid;
    logic                   par_err_q;
    logic                   valid_q;
    logic                   ferr_q;
    logic                   perr_q;
    logic                   overrun_q;

    assign rxs = sync_q[SYNC_STAGES-1];
    // Start samples at half a bit after detect; every later sample is a full bit apart.
    assign mid = (state_q == START) ? (tick_q == HALF) : (tick_q == FULL);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q     <= '1;
            rxs_prev_q <= 1'b1;
            armed_q    <= 1'b0;
            state_q    <= IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_i};
            overrun_q <= 1'b0;
            if (valid_q && ready_i) valid_q <= 1'b0;
            if (baud_tick_i) begin
                rxs_prev_q <= rxs;
                tick_q     <= (state_q == IDLE || mid) ? '0 : tick_q + 1'b1;
                case (state_q)
                    IDLE: begin
                        if (armed_q && rxs_prev_q && !rxs) begin
                            armed_q <= 1'b0;
                            state_q <= START;
                        end else if (rxs) begin
                            armed_q <= 1'b1;
                        end
                    end
                    START: if (mid) state_q <= rxs ? IDLE : DATA;
                    DATA: begin
                        if (mid) begin
                            shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
                            bit_q   <= (bit_q == LAST) ? '0 : bit_q + 1'b1;
                            if (bit_q == LAST) state_q <= AFTER_DATA;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (mid) begin
                            par_err_q <= ^shift_q ^ rxs ^ parity_odd_i;
                            state_q   <= STOP;
                        end
                    end
`endif
                    STOP: begin
                        if (mid) begin
                            state_q <= IDLE;
                            if (!valid_q || ready_i) begin
                                data_q  <= shift_q;
                                ferr_q  <= !rxs;
                                perr_q  <= par_err_q;
                                valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign frame_err_o  = ferr_q;
    assign parity_err_o = perr_q;
    assign overrun_o    = overrun_q;
    assign busy_o       = (state_q != IDLE);
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

UART receive controller that sequences reception of one serial character from the asynchronous `rx_i` line. Internally synchronizes `rx_i` and oversamples it at `OVERSAMPLE` × baud using an external tick. Validates the start bit, shifts in data LSB-first, checks stop (and optionally parity), and presents each character on a valid/ready output handshake. Sits between the pad-side RX pin and the UART receive FIFO/register interface.

## Interface
- `DATA_BITS`, 8, data bits per character (5..9)
- `OVERSAMPLE`, 16, baud ticks per bit period (even, ≥ 4)
- `SYNC_STAGES`, 2, synchronizer flop depth on `rx_i` (≥ 2)
- `clk_i`  input  1  system clock; all logic on rising edge
- `rst_i`  input  1  reset, synchronous, active-high
- `rx_i`  input  1  asynchronous serial line, idle high
- `baud_tick_i`  input  1  one-cycle pulse at OVERSAMPLE × baud rate
- `data_o`  output  DATA_BITS  received character, LSB = first bit on line
- `valid_o`  output  1  `data_o`/error flags hold a character
- `ready_i`  input  1  consumer accepts when `valid_o && ready_i`
- `frame_err_o`  output  1  stop bit sampled low for the held character
- `parity_err_o`  output  1  parity mismatch for the held character (0 when parity compiled out)
- `overrun_o`  output  1  one-cycle pulse: completed character dropped
- `busy_o`  output  1  FSM not in IDLE

## Operation
- Synchronizer: `SYNC_STAGES` flops on `rx_i`, reset to 1. `rxs` denotes its output. `rxs_d` is `rxs` registered on each `baud_tick_i`.
- The FSM and counters advance only on cycles with `baud_tick_i = 1`. `tick_cnt` has width clog2(OVERSAMPLE); `bit_cnt` counts data bits.
- IDLE: `armed` is set when `rxs = 1` is seen. Start is detected when `armed`, `rxs_d = 1`, `rxs = 0`. Detection clears `tick_cnt` and `armed` and moves to START.
- START: at `tick_cnt = OVERSAMPLE/2 - 1` (mid-bit), sample `rxs`.
  - `rxs = 1`: false start, go to IDLE, nothing reported.
  - `rxs = 0`: clear `tick_cnt`, go to DATA.
- DATA: sample at `tick_cnt = OVERSAMPLE - 1` (mid-bit thereafter). Shift the sample into the MSB of the shift register (right shift). After `DATA_BITS` samples go to PARITY (if compiled in) or STOP.
- PARITY: one sample, compared against the configured parity.
- STOP: one sample.
  - `rxs = 0` sets the frame error.
  - In either case the character completes and the FSM returns to IDLE immediately at mid-stop, giving half a bit of resync margin.
- Break / held-low line: `armed` stays clear until the line returns high, so no retrigger.
- Output register, updated on the cycle after completion:
  - `valid_o = 0`, or `ready_i = 1` in the completion cycle: load `data_o`, `frame_err_o`, `parity_err_o`; set `valid_o`.
  - Otherwise: keep the old character, pulse `overrun_o` for 1 cycle, discard the new one.
  - `valid_o` clears on handshake unless a new load happens in the same cycle.
- Frame-errored characters are still delivered, with the flag set.

## Timing
- Reset: all outputs 0, FSM IDLE, counters 0, synchronizer flops 1, `armed = 0`. The first high `rxs` after reset arms the FSM.
- Reset asserted mid-character: the character is discarded; no `valid_o` or `overrun_o`.
- Line-to-detect latency: `SYNC_STAGES` clocks plus up to one tick period.
- `valid_o` rises 1 clk after the `baud_tick_i` cycle that samples the stop bit.
- `overrun_o` pulses in that same cycle.
- `busy_o` is registered from the state: high from the detect tick + 1 clk until the stop-sample tick + 1 clk.
- Data, error flags, and `valid_o` are stable while `valid_o && !ready_i`.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state is present.
  - Extra input `parity_odd_i` (1 bit, static): 0 = even, 1 = odd.
  - `parity_err_o` is set when the XOR of the data bits and the parity bit ≠ `parity_odd_i`.
- Not defined:
  - No PARITY state; STOP directly follows the last data bit.
  - `parity_err_o` is tied to 0.
  - `parity_odd_i` is absent.

## Test plan
- Reset, OVERSAMPLE=16, DATA_BITS=8, line idle high, send 0xA5 at 16 ticks/bit, `ready_i = 1` -> one `valid_o` pulse, `data_o = 0xA5`, both error flags 0.
- Low glitch of 4 ticks on the idle line -> FSM returns to IDLE at tick 8, no `valid_o`, `busy_o` low afterwards.
- Send 0x3C with the stop bit forced low, followed by 20 bit-times of line low -> `data_o = 0x3C`, `frame_err_o = 1`, no second character until the line goes high and a new start arrives.
- `ready_i = 0`, send 0x11 then 0x22 -> `data_o` stays 0x11, `overrun_o` pulses once at 0x22 completion. Then raise `ready_i` -> `valid_o` falls.
- `ready_i` pulsed in the exact cycle 0x22 completes while 0x11 is held -> 0x11 is consumed, `data_o = 0x22`, `valid_o` stays high, no overrun.
- With `UART_RX_PARITY_EN`, `parity_odd_i = 0`: send 0x07 with parity bit 0 -> `parity_err_o = 1`. Send 0x07 with parity bit 1 -> `parity_err_o = 0`. Separately, assert `rst_i` at DATA bit 3 -> no `valid_o`, all outputs 0.
